dac_playback_reader: RTL and testbench

//  Read side of the 32K x 8 DAC sample buffer. Host logic writes a waveform through the

---
 rtl/dac_pkg.sv | 7 +
 rtl/dac_rate_tick.sv | 18 +
 rtl/dac_playback_reader.sv | 79 +++++++
 tb/tb_dac_playback_reader.sv | 133 +++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// dac_pkg: shared widths, read latency and FSM encoding for the DAC playback path
package dac_pkg;
  localparam int DAC_ADDR_W = 15;
  localparam int DAC_DATA_W = 8;
  localparam int DAC_RD_LAT = 2;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} dac_state_e;
endpackage

// File: rtl/dac_rate_tick.sv
// dac_rate_tick: down-counter that ticks once every div+1 enabled clocks, first tick immediately
module dac_rate_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;
  assign tick = en && cnt == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? div : cnt - 1'b1;
endmodule

// File: rtl/dac_playback_reader.sv
// dac_playback_reader: walks an address window of the sample buffer at a programmed rate
// and hands each sample to the DAC driver with a strobe, one-shot or looping.
module dac_playback_reader
  import dac_pkg::*;
#(
  parameter int ADDR_W = DAC_ADDR_W,
  parameter int DATA_W = DAC_DATA_W,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [DIV_W-1:0]  rate_div,
  output logic [ADDR_W-1:0] bram_adb,
  output logic              bram_ceb,
  output logic              bram_oce,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_strobe,
  output logic              busy,
  output logic              done
);
  dac_state_e state, state_nx;
  logic [ADDR_W-1:0] addr, start_q, end_q, adb_q;
  logic [DIV_W-1:0] div_q;
  logic [DAC_RD_LAT:0] vld;
  logic tick, iss, last, accept;
  dac_rate_tick #(.DIV_W(DIV_W)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state == IDLE),
    .en   (state == RUN),
    .div  (div_q),
    .tick (tick)
  );
  assign accept = state == IDLE && start && !stop;
  assign iss = state == RUN && tick && !stop;
  assign last = addr == end_q;
  assign bram_ceb = iss;
  assign bram_adb = iss ? addr : adb_q;
  assign bram_oce = vld[0];
  assign dac_strobe = vld[DAC_RD_LAT];
  assign busy = state != IDLE;
  assign done = state == DRAIN && vld == '0;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (accept ? RUN : IDLE)
             : state == RUN  ? (stop || (iss && last && !loop_en) ? DRAIN : RUN)
             : (vld == '0 ? IDLE : DRAIN);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      start_q <= '0;
      end_q <= '0;
      adb_q <= '0;
      div_q <= '0;
      vld <= '0;
      dac_data <= '0;
    end else begin
      state <= state_nx;
      vld <= {vld[DAC_RD_LAT-1:0], iss};
      if (accept) begin
        addr <= start_addr;
        start_q <= start_addr;
        end_q <= end_addr;
        div_q <= rate_div;
      end else if (iss) begin
        addr <= last ? start_q : addr + 1'b1;
        adb_q <= addr;
      end
      if (vld[DAC_RD_LAT-1]) dac_data <= bram_dout;
    end
endmodule

// File: tb/tb_dac_playback_reader.sv
// tb_dac_playback_reader: randomized playback runs checked cycle by cycle against
// an issue schedule computed from window length, rate and stop time.
module tb_dac_playback_reader;
  logic clk = 0, rst_n = 0, start = 0, stop = 0, loop_en = 0;
  logic [14:0] start_addr = 0, end_addr = 0, bram_adb;
  logic [15:0] rate_div = 0;
  logic bram_ceb, bram_oce, dac_strobe, busy, done;
  logic [7:0] bram_dout, dac_data;
  logic [7:0] mem [0:32767];
  logic [14:0] ram_a;
  int checks = 0, fails = 0;
  logic [7:0] last_data = 0;
  logic [14:0] last_adb = 0;

  always #5 clk = ~clk;

  dac_playback_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .start_addr(start_addr), .end_addr(end_addr), .rate_div(rate_div),
    .bram_adb(bram_adb), .bram_ceb(bram_ceb), .bram_oce(bram_oce), .bram_dout(bram_dout),
    .dac_data(dac_data), .dac_strobe(dac_strobe), .busy(busy), .done(done)
  );

  always @(posedge clk) begin
    if (bram_ceb) ram_a <= bram_adb;
    if (bram_oce) bram_dout <= mem[ram_a];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic idle_chk(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("idle_ceb", bram_ceb, 0);
      chk("idle_stb", dac_strobe, 0);
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_adb", bram_adb, last_adb);
      chk("idle_data", dac_data, last_data);
    end
  endtask

  // stop_rel < 0 means no stop; loop runs must supply one
  task automatic play(input int sa, input int ea, input int dv, input int lp,
                      input int stop_rel, input int busy_start);
    int len, last_rel, done_rel, n;
    int ia[int];
    int sd[int];
    len = ((ea - sa) & 'h7fff) + 1;
    n = 0;
    for (int k = 0; ; k++) begin
      int r = k * (dv + 1);
      if (stop_rel >= 0 && r >= stop_rel) break;
      if (!lp && k >= len) break;
      ia[r] = (sa + k % len) & 'h7fff;
      sd[r + 3] = mem[ia[r]];
      last_rel = r;
      n++;
    end
    done_rel = (!lp && n == len) ? last_rel + 4
             : (stop_rel + 1 > last_rel + 4 ? stop_rel + 1 : last_rel + 4);
    @(posedge clk); #1;
    start_addr = sa[14:0]; end_addr = ea[14:0]; rate_div = dv[15:0];
    loop_en = lp[0]; start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int rel = 0; rel <= done_rel + 2; rel++) begin
      if (rel > 0) begin @(posedge clk); #1; end
      stop = (rel == stop_rel);
      start = busy_start != 0 && rel == 1;
      if (start) start_addr = sa[14:0] ^ 15'h0555;
      @(negedge clk);
      chk("ceb", bram_ceb, ia.exists(rel));
      if (ia.exists(rel)) last_adb = ia[rel][14:0];
      chk("adb", bram_adb, last_adb);
      chk("oce", bram_oce, ia.exists(rel - 1));
      chk("stb", dac_strobe, sd.exists(rel));
      if (sd.exists(rel)) last_data = sd[rel][7:0];
      chk("data", dac_data, last_data);
      chk("done", done, rel == done_rel);
      chk("busy", busy, rel <= done_rel);
    end
    stop = 0; start = 0;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
    for (int i = 16; i < 20; i++) mem[i] = 8'(i);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ceb", bram_ceb, 0); chk("rst_oce", bram_oce, 0);
    chk("rst_adb", bram_adb, 0); chk("rst_data", dac_data, 0);
    chk("rst_stb", dac_strobe, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    @(negedge clk) rst_n = 1;
    play('h10, 'h13, 0, 0, -1, 0);
    play(0, 2, 3, 0, -1, 0);
    play('h7ffe, 1, 0, 1, 6, 0);
    @(posedge clk); #1 start = 1; stop = 1;
    @(posedge clk); #1 start = 0; stop = 0;
    idle_chk(4);
    play('h200, 'h205, 1, 0, -1, 1);
    play('h1234, 'h1234, 1, 1, 9, 0);
    for (int t = 0; t < 12; t++) begin
      int sa, lp, sr;
      sa = $urandom_range(0, 32767);
      lp = $urandom_range(0, 1);
      sr = (lp != 0 || $urandom_range(0, 1) != 0) ? $urandom_range(1, 30) : -1;
      play(sa, (sa + $urandom_range(0, 7)) & 'h7fff, $urandom_range(0, 3), lp, sr,
           $urandom_range(0, 1));
    end
    @(posedge clk); #1;
    start_addr = 15'h100; end_addr = 15'h1ff; rate_div = 0; loop_en = 0; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (4) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("arst_ceb", bram_ceb, 0); chk("arst_oce", bram_oce, 0);
    chk("arst_adb", bram_adb, 0); chk("arst_data", dac_data, 0);
    chk("arst_stb", dac_strobe, 0); chk("arst_busy", busy, 0); chk("arst_done", done, 0);
    last_data = 0; last_adb = 0;
    @(negedge clk) rst_n = 1;
    idle_chk(5);
    play('h10, 'h13, 0, 0, -1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
